// File: rtl/collision_reader_pkg.sv
// Shared types and constants for the board-collision reader: board limits,
// direction codes, head-position layout and the one-cell step rule.
package collision_reader_pkg;

  localparam int unsigned X_MAX_DEF     = 160;
  localparam int unsigned Y_MAX_DEF     = 120;
  localparam logic [2:0]  BG_COLOUR_DEF = 3'b000;
  localparam int unsigned N_PLAYERS     = 4;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
  } pos_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CALC    = 3'd1,
    ST_ADDR    = 3'd2,
    ST_WAIT    = 3'd3,
    ST_CHECK   = 3'd4,
    ST_RESOLVE = 3'd5,
    ST_DONE    = 3'd6
  } state_t;

  // Fields wrap at their own width, so moving off an edge lands far out of range.
  function automatic pos_t step_pos(input pos_t p, input logic [1:0] dir);
    pos_t n;
    n = p;
    case (dir)
      DIR_UP:    n.y = p.y - 7'd1;
      DIR_DOWN:  n.y = p.y + 7'd1;
      DIR_LEFT:  n.x = p.x - 8'd1;
      DIR_RIGHT: n.x = p.x + 8'd1;
      default:   n = p;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/collision_reader_if.sv
// Tick handshake, player inputs, board RAM read port and alive flags of the
// collision reader; slave is the reader itself, master is the surrounding game.
interface collision_reader_if;

  logic        start;
  logic [14:0] p1;
  logic [14:0] p2;
  logic [14:0] p3;
  logic [14:0] p4;
  logic [1:0]  p1d;
  logic [1:0]  p2d;
  logic [1:0]  p3d;
  logic [1:0]  p4d;
  logic [14:0] ram_address;
  logic [2:0]  ram_q;
  logic        busy;
  logic        done;
  logic [3:0]  alive;

  modport slave (
    input  start, p1, p2, p3, p4, p1d, p2d, p3d, p4d, ram_q,
    output ram_address, busy, done, alive
  );

  modport master (
    output start, p1, p2, p3, p4, p1d, p2d, p3d, p4d, ram_q,
    input  ram_address, busy, done, alive
  );

endinterface

// File: rtl/collision_reader_next_pos.sv
// Combinational next-cell and off-board flag for one player; the movement
// logic instantiates the same block so collision and motion always agree.
module collision_reader_next_pos
  import collision_reader_pkg::*;
#(
  parameter int unsigned X_MAX = X_MAX_DEF,
  parameter int unsigned Y_MAX = Y_MAX_DEF
) (
  input  pos_t       pos_i,
  input  logic [1:0] dir_i,
  output pos_t       next_o,
  output logic       oob_o
);

  localparam logic [8:0] X_LIM = 9'(X_MAX);
  localparam logic [7:0] Y_LIM = 8'(Y_MAX);

  pos_t next_s;
  logic oob_s;

  // Step the head and flag any coordinate beyond the board.
  always_comb begin
    next_s = step_pos(pos_i, dir_i);
    oob_s  = ({1'b0, next_s.x} >= X_LIM) || ({1'b0, next_s.y} >= Y_LIM);
  end

  assign next_o = next_s;
  assign oob_o  = oob_s;

endmodule

// File: rtl/collision_reader.sv
// Per-tick collision scan: reads each player's next cell from the board RAM,
// then kills players that hit a trail, leave the board or meet head-on.
module collision_reader
  import collision_reader_pkg::*;
#(
  parameter int unsigned X_MAX       = X_MAX_DEF,
  parameter int unsigned Y_MAX       = Y_MAX_DEF,
  parameter logic [2:0]  BG_COLOUR   = BG_COLOUR_DEF,
  parameter int unsigned RAM_LATENCY = 1
) (
  input logic               CLOCK_50,
  input logic               reset,
  collision_reader_if.slave bus
);

  localparam int unsigned    WCNT_W = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;
  localparam logic [WCNT_W-1:0] LAT_M1 = WCNT_W'(RAM_LATENCY - 1);
  localparam logic [WCNT_W-1:0] W_ONE  = WCNT_W'(1);

  pos_t        pos_s  [N_PLAYERS];
  logic [1:0]  dir_s  [N_PLAYERS];
  pos_t        step_s [N_PLAYERS];
  logic [3:0]  oob_s;
  logic [3:0]  clash_s;

  state_t            state_q;
  pos_t              next_q [N_PLAYERS];
  logic [3:0]        oob_q;
  logic [3:0]        hit_q;
  logic [3:0]        alive_q;
  logic [1:0]        idx_q;
  logic [WCNT_W-1:0] wait_q;
  logic [14:0]       ram_address_q;
  logic              busy_q;
  logic              done_q;

  assign pos_s[0] = bus.p1;
  assign pos_s[1] = bus.p2;
  assign pos_s[2] = bus.p3;
  assign pos_s[3] = bus.p4;
  assign dir_s[0] = bus.p1d;
  assign dir_s[1] = bus.p2d;
  assign dir_s[2] = bus.p3d;
  assign dir_s[3] = bus.p4d;

  for (genvar gi = 0; gi < N_PLAYERS; gi++) begin : g_np
    collision_reader_next_pos #(
      .X_MAX (X_MAX),
      .Y_MAX (Y_MAX)
    ) u_next_pos (
      .pos_i  (pos_s[gi]),
      .dir_i  (dir_s[gi]),
      .next_o (step_s[gi]),
      .oob_o  (oob_s[gi])
    );
  end

  // Head-on detection among live players only; dead players cannot kill.
  always_comb begin
    clash_s = 4'b0000;
    for (int i = 0; i < N_PLAYERS; i++) begin
      for (int j = 0; j < N_PLAYERS; j++) begin
        if ((i != j) && alive_q[i] && alive_q[j] && (next_q[i] == next_q[j])) begin
          clash_s[i] = 1'b1;
        end else begin
          clash_s[i] = clash_s[i];
        end
      end
    end
  end

  // Scan sequencer: every player is read even when dead so latency is fixed.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      alive_q       <= 4'b1111;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      ram_address_q <= 15'd0;
      oob_q         <= 4'b0000;
      hit_q         <= 4'b0000;
      idx_q         <= 2'd0;
      wait_q        <= '0;
      for (int i = 0; i < N_PLAYERS; i++) begin
        next_q[i] <= 15'd0;
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_q <= ST_CALC;
            busy_q  <= 1'b1;
          end
        end
        ST_CALC: begin
          for (int i = 0; i < N_PLAYERS; i++) begin
            next_q[i] <= step_s[i];
          end
          oob_q   <= oob_s;
          hit_q   <= 4'b0000;
          idx_q   <= 2'd0;
          state_q <= ST_ADDR;
        end
        ST_ADDR: begin
          // Off-board cells would alias real ones, so read a harmless address.
          ram_address_q <= oob_q[idx_q] ? 15'd0 : next_q[idx_q];
          wait_q        <= '0;
          state_q       <= ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_q == LAT_M1) begin
            state_q <= ST_CHECK;
          end else begin
            wait_q <= wait_q + W_ONE;
          end
        end
        ST_CHECK: begin
          hit_q[idx_q] <= oob_q[idx_q] | (bus.ram_q != BG_COLOUR);
          if (idx_q == 2'd3) begin
            state_q <= ST_RESOLVE;
          end else begin
            idx_q   <= idx_q + 2'd1;
            state_q <= ST_ADDR;
          end
        end
        ST_RESOLVE: begin
          alive_q <= alive_q & ~(hit_q | clash_s);
          done_q  <= 1'b1;
          state_q <= ST_DONE;
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ram_address = ram_address_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.alive       = alive_q;

endmodule
